decoder_onehot_pipe: RTL

- Parametrised, pipelined successor to the team's BCD-style code-to-one-hot decoder.
- Accepts CODE_W-bit codes on a valid/ready stream.
- Maps each code to an OUT_W-bit one-hot or thermometer word.
- Flags out-of-range codes and counts them.
- Sits between a code producer and downstream select/enable logic, with full-throughput backpressure via a 2-entry skid buffer.

---
 rtl/decoder_onehot_pipe_if.sv | 28 ++
 rtl/decoder_onehot_pipe.sv | 107 ++++++++++
 2 files changed

// File: rtl/decoder_onehot_pipe_if.sv
// Code-in / decoded-word-out stream bundle for decoder_onehot_pipe.
// Signal names are seen from the decoder: i_* flow into it, o_* flow out of it.
interface decoder_onehot_pipe_if #(
    parameter int unsigned CODE_W = 4,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned CNT_W  = 8
);
    logic              i_valid;
    logic              o_ready;
    logic [CODE_W-1:0] i_data;
    logic              i_mode;
    logic              o_valid;
    logic              i_ready;
    logic [OUT_W-1:0]  o_decode;
    logic              o_err;
    logic              i_err_clr;
    logic [CNT_W-1:0]  o_err_cnt;

    modport slave (
        input  i_valid, i_data, i_mode, i_ready, i_err_clr,
        output o_ready, o_valid, o_decode, o_err, o_err_cnt
    );

    modport master (
        output i_valid, i_data, i_mode, i_ready, i_err_clr,
        input  o_ready, o_valid, o_decode, o_err, o_err_cnt
    );
endinterface

// File: rtl/decoder_onehot_pipe.sv
// Pipelined code-to-one-hot/thermometer decoder on a valid/ready stream.
// A main output register and one skid register keep full throughput under backpressure.
module decoder_onehot_pipe #(
    parameter int unsigned CODE_W = 4,
    parameter int unsigned OUT_W  = 10,
    parameter int unsigned BASE   = 1,
    parameter int unsigned CNT_W  = 8
) (
    input logic                 i_clk,
    input logic                 i_rst,
    decoder_onehot_pipe_if.slave bus
);
    localparam logic [CODE_W:0]  BaseExt = (CODE_W+1)'(BASE);
    localparam logic [CODE_W:0]  OutWExt = (CODE_W+1)'(OUT_W);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e           state_q;
    logic             ready_q;
    logic [OUT_W-1:0] main_dec_q, skid_dec_q;
    logic             main_err_q, skid_err_q;
    logic [CNT_W-1:0] err_cnt_q;

    logic [CODE_W:0]  code_ext, idx;
    logic             in_range;
    logic [OUT_W-1:0] dec_new;
    logic             accept, xfer;

    // One extra bit so codes below BASE wrap to a large idx instead of aliasing.
    assign code_ext = {1'b0, bus.i_data};
    assign idx      = code_ext - BaseExt;
    assign in_range = (code_ext >= BaseExt) && (idx < OutWExt);

    always_comb begin
        dec_new = '0;
        if (in_range) begin
            for (int i = 0; i < int'(OUT_W); i++) begin
                dec_new[i] = bus.i_mode ? ((CODE_W+1)'(i) <= idx) : ((CODE_W+1)'(i) == idx);
            end
        end
    end

    assign accept = bus.i_valid & ready_q;
    assign xfer   = (state_q != StEmpty) & bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StEmpty;
            ready_q    <= 1'b0;
            main_dec_q <= '0;
            main_err_q <= 1'b0;
            skid_dec_q <= '0;
            skid_err_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            ready_q <= 1'b1;
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_dec_q <= dec_new;
                        main_err_q <= ~in_range;
                        state_q    <= StOne;
                    end
                end
                StOne: begin
                    if (accept && !xfer) begin
                        skid_dec_q <= dec_new;
                        skid_err_q <= ~in_range;
                        state_q    <= StTwo;
                        ready_q    <= 1'b0;
                    end else if (accept) begin
                        main_dec_q <= dec_new;
                        main_err_q <= ~in_range;
                    end else if (xfer) begin
                        main_dec_q <= '0;
                        main_err_q <= 1'b0;
                        state_q    <= StEmpty;
                    end
                end
                StTwo: begin
                    // ready_q is low here, so no accept can collide with the drain.
                    if (xfer) begin
                        main_dec_q <= skid_dec_q;
                        main_err_q <= skid_err_q;
                        state_q    <= StOne;
                    end else begin
                        ready_q <= 1'b0;
                    end
                end
                default: state_q <= StEmpty;
            endcase

            if (bus.i_err_clr) begin
                err_cnt_q <= (accept && !in_range) ? CNT_W'(1) : '0;
            end else if (accept && !in_range && err_cnt_q != CntMax) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_valid   = (state_q != StEmpty);
    assign bus.o_decode  = main_dec_q;
    assign bus.o_err     = main_err_q;
    assign bus.o_err_cnt = err_cnt_q;
endmodule
